// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default width
// and width-dependent constants.
package alu_pkg;

    localparam int DIV_LEN = 9;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    function automatic logic [63:0] MIN_VAL(input int len);
        return 64'd1 << (len - 1);
    endfunction

    function automatic logic [63:0] NEG_ONE(input int len);
        return ~64'd0 >> (64 - len);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for the sequential divider.
// The master side is the issuing datapath; the slave side is the divider.
interface seq_divider_if
    import alu_pkg::*;
#(
    parameter int LEN = DIV_LEN
);

    logic           in_valid;
    logic           in_ready;
    logic [LEN-1:0] dividend;
    logic [LEN-1:0] divisor;
    logic           out_valid;
    logic           out_ready;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero,
        output overflow
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep or restore.
module div_step
    import alu_pkg::*;
#(
    parameter int LEN = DIV_LEN
) (
    input  logic [LEN:0]   rem_i,
    input  logic           bit_i,
    input  logic [LEN-1:0] dsr_i,
    output logic [LEN:0]   rem_o,
    output logic           q_o
);

    logic [LEN:0] sh;
    logic [LEN:0] diff;

    always_comb begin
        sh    = {rem_i[LEN-1:0], bit_i};
        diff  = sh - {1'b0, dsr_i};
        // A set top bit means the shifted value already exceeds any divisor.
        q_o   = rem_i[LEN] | ~diff[LEN];
        rem_o = q_o ? diff : sh;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider with valid/ready on both sides,
// divide-by-zero and MIN/-1 overflow detection.
module seq_divider
    import alu_pkg::*;
#(
    parameter int LEN = DIV_LEN
) (
    input  logic         clk,
    input  logic         rstn,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(LEN);
    localparam logic [LEN-1:0] MIN_V  = LEN'(MIN_VAL(LEN));
    localparam logic [LEN-1:0] NEG1_V = LEN'(NEG_ONE(LEN));

    div_state_t     state_q;
    logic [CW-1:0]  cnt_q;
    logic [LEN:0]   rem_q;
    logic [LEN-1:0] dvd_q;
    logic [LEN-1:0] dsr_q;
    logic [LEN-1:0] a_q;
    logic [LEN-1:0] b_q;
    logic           nq_q;
    logic           nr_q;
    logic           dz_q;
    logic           ov_q;
    logic           rdy_q;
    logic           vld_q;
    logic           dbz_q;
    logic           ovf_q;
    logic [LEN-1:0] quo_q;
    logic [LEN-1:0] rmd_q;

    logic [LEN-1:0] mag_a_d;
    logic [LEN-1:0] mag_b_d;
    logic           is_dz_d;
    logic           is_ov_d;
    logic [LEN:0]   step_rem;
    logic           step_q;

    always_comb begin
        mag_a_d = a_q[LEN-1] ? -a_q : a_q;
        mag_b_d = b_q[LEN-1] ? -b_q : b_q;
        is_dz_d = (b_q == '0);
        is_ov_d = (a_q == MIN_V) && (b_q == NEG1_V);
    end

    div_step #(.LEN(LEN)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[LEN-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && rdy_q) begin
                        a_q     <= bus.dividend;
                        b_q     <= bus.divisor;
                        rdy_q   <= 1'b0;
                        dbz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    // Special cases preload the final values and pass
                    // through FIX with negation disabled.
                    unique case (1'b1)
                        is_dz_d: begin
                            dvd_q   <= NEG1_V;
                            rem_q   <= {1'b0, a_q};
                            nq_q    <= 1'b0;
                            nr_q    <= 1'b0;
                            dz_q    <= 1'b1;
                            ov_q    <= 1'b0;
                            state_q <= FIX;
                        end
                        is_ov_d: begin
                            dvd_q   <= MIN_V;
                            rem_q   <= '0;
                            nq_q    <= 1'b0;
                            nr_q    <= 1'b0;
                            dz_q    <= 1'b0;
                            ov_q    <= 1'b1;
                            state_q <= FIX;
                        end
                        default: begin
                            dvd_q   <= mag_a_d;
                            dsr_q   <= mag_b_d;
                            rem_q   <= '0;
                            nq_q    <= a_q[LEN-1] ^ b_q[LEN-1];
                            nr_q    <= a_q[LEN-1];
                            dz_q    <= 1'b0;
                            ov_q    <= 1'b0;
                            cnt_q   <= CW'(LEN - 1);
                            state_q <= ITER;
                        end
                    endcase
                end
                ITER: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[LEN-2:0], step_q};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    quo_q   <= nq_q ? -dvd_q : dvd_q;
                    rmd_q   <= nr_q ? -rem_q[LEN-1:0] : rem_q[LEN-1:0];
                    dbz_q   <= dz_q;
                    ovf_q   <= ov_q;
                    vld_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = vld_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (LEN=9).
// Each scenario task drives its stimulus and checks inline.
module tb_seq_divider;
    import alu_pkg::*;

    localparam int LEN = 9;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if #(.LEN(LEN)) bus ();

    seq_divider #(.LEN(LEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Issue one operation; return cycles to out_valid (-1 on timeout),
    // whether in_ready was ever seen high while busy, and the flags
    // sampled just after the accept edge.
    task automatic run_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          input logic early, output int lat,
                          output logic busy_rdy, output logic [1:0] fl_acc);
        @(negedge clk);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = early;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        busy_rdy = bus.in_ready;
        fl_acc   = {bus.div_by_zero, bus.overflow};
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
            busy_rdy |= bus.in_ready;
        end
    endtask

    task automatic ack(output logic rdy, output logic vld);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        rdy = bus.in_ready;
        vld = bus.out_valid;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #2;
        checks++;
        if ({bus.out_valid, bus.quotient, bus.remainder,
             bus.div_by_zero, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got v=%b q=%h r=%h dz=%b ov=%b want all 0",
                     bus.out_valid, bus.quotient, bus.remainder,
                     bus.div_by_zero, bus.overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got rdy=%b v=%b want rdy=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_special();
        logic [LEN-1:0] va [3];
        logic [LEN-1:0] vb [3];
        logic [LEN-1:0] vq [3];
        logic [LEN-1:0] vr [3];
        logic [1:0]     vf [3];
        int lat;
        logic br, rdy, vld;
        logic [1:0] fa;
        va = '{9'd5, 9'h100, 9'd0};
        vb = '{9'd0, 9'h1FF, 9'd0};
        vq = '{9'h1FF, 9'h100, 9'h1FF};
        vr = '{9'd5, 9'd0, 9'd0};
        vf = '{2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, br, fa);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL sp%0d_lat: got %0d want 2", i, lat);
            end
            checks++;
            if (bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
                errors++;
                $display("FAIL sp%0d_qr: got q=%h r=%h want q=%h r=%h",
                         i, bus.quotient, bus.remainder, vq[i], vr[i]);
            end
            checks++;
            if ({bus.div_by_zero, bus.overflow} !== vf[i]) begin
                errors++;
                $display("FAIL sp%0d_flags: got %b want %b", i,
                         {bus.div_by_zero, bus.overflow}, vf[i]);
            end
            ack(rdy, vld);
            checks++;
            if (rdy !== 1'b1 || vld !== 1'b0) begin
                errors++;
                $display("FAIL sp%0d_ack: got rdy=%b v=%b want 1 0", i, rdy, vld);
            end
        end
    endtask

    task automatic test_normal();
        logic [LEN-1:0] va [10];
        logic [LEN-1:0] vb [10];
        logic [LEN-1:0] vq [10];
        logic [LEN-1:0] vr [10];
        int lat;
        logic br, rdy, vld;
        logic [1:0] fa;
        va = '{9'd100, 9'h19C, 9'd100,  9'h1F9, 9'd3,
               9'h0FF, 9'h100, 9'h100,  9'h100, 9'h19C};
        vb = '{9'd7,   9'd7,   9'h1F9,  9'd2,   9'd5,
               9'h100, 9'd7,   9'd1,    9'h1FE, 9'h1F9};
        vq = '{9'd14,  9'h1F2, 9'h1F2,  9'h1FD, 9'd0,
               9'd0,   9'h1DC, 9'h100,  9'h080, 9'd14};
        vr = '{9'd2,   9'h1FE, 9'd2,    9'h1FF, 9'd3,
               9'h0FF, 9'h1FC, 9'd0,    9'd0,   9'h1FE};
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, br, fa);
            checks++;
            if (fa !== 2'b00) begin
                errors++;
                $display("FAIL n%0d_flag_clear: got %b want 00", i, fa);
            end
            checks++;
            if (br !== 1'b0) begin
                errors++;
                $display("FAIL n%0d_busy_rdy: got %b want 0", i, br);
            end
            checks++;
            if (lat !== 11) begin
                errors++;
                $display("FAIL n%0d_lat: got %0d want 11", i, lat);
            end
            checks++;
            if (bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
                errors++;
                $display("FAIL n%0d_qr: got q=%h r=%h want q=%h r=%h",
                         i, bus.quotient, bus.remainder, vq[i], vr[i]);
            end
            checks++;
            if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
                errors++;
                $display("FAIL n%0d_flags: got %b want 00", i,
                         {bus.div_by_zero, bus.overflow});
            end
            ack(rdy, vld);
            checks++;
            if (rdy !== 1'b1 || vld !== 1'b0) begin
                errors++;
                $display("FAIL n%0d_ack: got rdy=%b v=%b want 1 0", i, rdy, vld);
            end
        end
    endtask

    task automatic test_early_ready();
        int lat;
        logic br, rdy, vld;
        logic [1:0] fa;
        run_op(9'd100, 9'd7, 1'b1, lat, br, fa);
        checks++;
        if (lat !== 11 || bus.quotient !== 9'd14 || bus.remainder !== 9'd2) begin
            errors++;
            $display("FAIL early_rdy: got lat=%0d q=%h r=%h want 11 00e 002",
                     lat, bus.quotient, bus.remainder);
        end
        ack(rdy, vld);
        checks++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL early_ack: got rdy=%b v=%b want 1 0", rdy, vld);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic br, rdy, vld;
        logic [1:0] fa;
        run_op(9'd100, 9'h1F9, 1'b0, lat, br, fa);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL bp_lat: got %0d want 11", lat);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 3 == 0);
            bus.dividend = 9'd50;
            bus.divisor  = 9'd3;
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.quotient !== 9'h1F2 || bus.remainder !== 9'd2) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b q=%h r=%h want 1 0 1f2 002",
                         i, bus.out_valid, bus.in_ready,
                         bus.quotient, bus.remainder);
            end
        end
        bus.in_valid = 1'b0;
        ack(rdy, vld);
        checks++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack: got rdy=%b v=%b want 1 0", rdy, vld);
        end
        run_op(9'd3, 9'd5, 1'b0, lat, br, fa);
        checks++;
        if (lat !== 11 || bus.quotient !== 9'd0 || bus.remainder !== 9'd3) begin
            errors++;
            $display("FAIL bp_next: got lat=%0d q=%h r=%h want 11 000 003",
                     lat, bus.quotient, bus.remainder);
        end
        ack(rdy, vld);
    endtask

    task automatic test_reset_midop();
        int lat;
        logic br, rdy, vld;
        logic [1:0] fa;
        run_op(9'h19C, 9'd7, 1'b0, lat, br, fa);
        ack(rdy, vld);
        @(negedge clk);
        bus.dividend = 9'd100;
        bus.divisor  = 9'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.quotient, bus.remainder,
             bus.div_by_zero, bus.overflow} !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_outs: got v=%b q=%h r=%h dz=%b ov=%b rdy=%b want 0s rdy=1",
                     bus.out_valid, bus.quotient, bus.remainder,
                     bus.div_by_zero, bus.overflow, bus.in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_op(9'd9, 9'd3, 1'b0, lat, br, fa);
        checks++;
        if (lat !== 11 || bus.quotient !== 9'd3 || bus.remainder !== 9'd0) begin
            errors++;
            $display("FAIL midrst_next: got lat=%0d q=%h r=%h want 11 003 000",
                     lat, bus.quotient, bus.remainder);
        end
        ack(rdy, vld);
        checks++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ack: got rdy=%b v=%b want 1 0", rdy, vld);
        end
    endtask

    initial begin
        test_reset();
        test_special();
        test_normal();
        test_early_ready();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
